// File: rtl/fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO controller.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, almost flags,
// sticky error flags and an optional first-word-fall-through read port.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    typedef logic [ADDR_WIDTH:0] cnt_t;
    localparam cnt_t AF_C   = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_C   = cnt_t'(AE_LEVEL);
    localparam cnt_t ONE_C  = cnt_t'(1);
    localparam logic AF_RST = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

    if (ADDR_WIDTH < 1) begin : g_chk_aw
        $error("sync_fifo_ctrl: ADDR_WIDTH must be at least 1");
    end
    if (AF_LEVEL > DEPTH) begin : g_chk_af
        $error("sync_fifo_ctrl: AF_LEVEL exceeds DEPTH");
    end
    if (AE_LEVEL > DEPTH) begin : g_chk_ae
        $error("sync_fifo_ctrl: AE_LEVEL exceeds DEPTH");
    end

    cnt_t                  wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic                  wfull_q, wfull_d, walmost_full_q, walmost_full_d;
    logic                  rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mem_rd_s;
    logic                  wa_s, ra_s;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wa_s),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ADDR_WIDTH-1:0]),
        .rdata (mem_rd_s)
    );

    // Next-state: accepts, pointers, and flags derived from the next pointers
    always_comb begin
        wa_s = winc && !wfull_q;
        ra_s = rinc && !rempty_q;

        if (wa_s) begin
            wptr_d = wptr_q + ONE_C;
        end else begin
            wptr_d = wptr_q;
        end
        if (ra_s) begin
            rptr_d = rptr_q + ONE_C;
        end else begin
            rptr_d = rptr_q;
        end

        count_d         = wptr_d - rptr_d;
        wfull_d         = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                          (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
        rempty_d        = (wptr_d == rptr_d);
        walmost_full_d  = (count_d >= AF_C);
        ralmost_empty_d = (count_d <= AE_C);

        // A rejected request sets its flag even when clr_err is high
        if (winc && wfull_q) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rinc && rempty_q) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end

        if (!FWFT && ra_s) begin
            rdata_d = mem_rd_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            walmost_full_q  <= AF_RST;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            rdata_q         <= '0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            walmost_full_q  <= walmost_full_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            rdata_q         <= rdata_d;
        end
    end

    // In FWFT mode the head word is shown only while the FIFO holds data
    if (FWFT) begin : g_fwft
        assign rdata = rempty_q ? {DATA_WIDTH{1'b0}} : mem_rd_s;
    end else begin : g_reg
        assign rdata = rdata_q;
    end

    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule
